spi_frame_checker: RTL

SPI_FRAME_CHECKER -- requirements
Module: spi_frame_checker

---
 rtl/spi_frame_checker.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_frame_checker.sv
// spi_frame_checker: passive SPI bus monitor that checks each csb-delimited frame.
// The first mosi word is looked up in a small command table; the entry says
// which word of the frame carries the CRC of the preceding mosi (rx) and
// miso (tx) words. At frame end the CRCs, truncation and command match are
// reported, and a saturating count of bad frames is kept.
//
// Ports
//   clk, rstb              block clock, synchronous active-low reset
//   sclk, mosi, miso, csb  monitored SPI bus (asynchronous to clk)
//   cfg_we, cfg_idx        command table write strobe and entry index
//   cfg_cmd                command code for the entry
//   cfg_rx_pos, cfg_tx_pos word index of the mosi / miso CRC word (0 = no check)
//   frame_done             one-clk pulse when a frame result is published
//   cmd_known, cmd_code    command match and first mosi word of the last frame
//   word_cnt               complete words in the last frame (saturating)
//   rx_crc_err, tx_crc_err, trunc_err  per-frame error flags
//   err_cnt                saturating count of frames with any error
module spi_frame_checker #(
  parameter int unsigned           DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] CRC_POLY   = 8'h2F,
  parameter logic [DATA_WIDTH-1:0] CRC_INIT   = 8'hFF,
  parameter logic [DATA_WIDTH-1:0] CRC_FINAL  = 8'hFF,
  parameter bit                    CPOL       = 1'b0,
  parameter bit                    CPHA       = 1'b0,
  parameter int unsigned           NUM_CMDS   = 8,
  parameter int unsigned           IDX_W      = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  sclk,
  input  logic                  mosi,
  input  logic                  miso,
  input  logic                  csb,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic [DATA_WIDTH-1:0] cfg_cmd,
  input  logic [DATA_WIDTH-1:0] cfg_rx_pos,
  input  logic [DATA_WIDTH-1:0] cfg_tx_pos,
  output logic                  frame_done,
  output logic                  cmd_known,
  output logic [DATA_WIDTH-1:0] cmd_code,
  output logic [DATA_WIDTH-1:0] word_cnt,
  output logic                  rx_crc_err,
  output logic                  tx_crc_err,
  output logic                  trunc_err,
  output logic [7:0]            err_cnt
);

  localparam int unsigned           BIT_W       = $clog2(DATA_WIDTH + 1);
  localparam bit                    SAMPLE_RISE = (CPOL == CPHA);
  localparam logic [BIT_W-1:0]      LAST_BIT    = BIT_W'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] WORD_MAX    = '1;

  typedef enum logic [1:0] {StIdle, StArmed, StActive, StCheck} state_t;

  // Synchronisers: [0] first flop, [1] synchronised value, [2] edge reference.
  logic [2:0] sclk_sync, csb_sync;
  logic [1:0] mosi_sync, miso_sync;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      sclk_sync <= {3{CPOL}};
      csb_sync  <= 3'b111;
      mosi_sync <= '0;
      miso_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[1:0], sclk};
      csb_sync  <= {csb_sync[1:0], csb};
      mosi_sync <= {mosi_sync[0], mosi};
      miso_sync <= {miso_sync[0], miso};
    end
  end

  logic sample_edge, csb_fall, csb_rise, mosi_bit, miso_bit;
  assign sample_edge = SAMPLE_RISE ? (sclk_sync[1] & ~sclk_sync[2])
                                   : (~sclk_sync[1] & sclk_sync[2]);
  assign csb_fall    = ~csb_sync[1] & csb_sync[2];
  assign csb_rise    = csb_sync[1] & ~csb_sync[2];
  assign mosi_bit    = mosi_sync[1];
  assign miso_bit    = miso_sync[1];

  // Command table
  logic [DATA_WIDTH-1:0] tbl_cmd [NUM_CMDS];
  logic [DATA_WIDTH-1:0] tbl_rx  [NUM_CMDS];
  logic [DATA_WIDTH-1:0] tbl_tx  [NUM_CMDS];
  logic [NUM_CMDS-1:0]   tbl_valid;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      tbl_valid <= '0;
    end else if (cfg_we) begin
      tbl_valid[cfg_idx] <= 1'b1;
    end
  end

  // Entry contents need no reset; the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (cfg_we) begin
      tbl_cmd[cfg_idx] <= cfg_cmd;
      tbl_rx[cfg_idx]  <= cfg_rx_pos;
      tbl_tx[cfg_idx]  <= cfg_tx_pos;
    end
  end

  // Frame state. Shift registers hold only DATA_WIDTH-1 bits: the bit that
  // completes a word is taken straight from the synchroniser.
  state_t                state_q;
  logic [1:0]            flush_q;
  logic [BIT_W-1:0]      bit_cnt_q;
  logic [DATA_WIDTH-1:0] word_cnt_q, rx_crc_q, tx_crc_q, rx_cap_q, tx_cap_q;
  logic [DATA_WIDTH-1:0] code_q, rx_pos_q, tx_pos_q;
  logic [DATA_WIDTH-2:0] rx_sr_q, tx_sr_q;
  logic                  known_q;

  logic [DATA_WIDTH-1:0] rx_word, tx_word;
  assign rx_word = {rx_sr_q, mosi_bit};
  assign tx_word = {tx_sr_q, miso_bit};

  // Lowest valid index matching the completing word wins.
  logic                  hit;
  logic [DATA_WIDTH-1:0] hit_rx, hit_tx;
  always_comb begin
    hit    = 1'b0;
    hit_rx = '0;
    hit_tx = '0;
    for (int i = 0; i < NUM_CMDS; i++) begin
      if (!hit && tbl_valid[i] && (tbl_cmd[i] == rx_word)) begin
        hit    = 1'b1;
        hit_rx = tbl_rx[i];
        hit_tx = tbl_tx[i];
      end
    end
  end

  function automatic logic [DATA_WIDTH-1:0] crc_step(input logic [DATA_WIDTH-1:0] crc,
                                                     input logic din);
    logic fb;
    fb       = crc[DATA_WIDTH-1] ^ din;
    crc_step = {crc[DATA_WIDTH-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
  endfunction

  // CRC positions are unknown until word 0 completes; word 0 is always covered.
  logic rx_crc_en, tx_crc_en;
  assign rx_crc_en = (word_cnt_q == '0) || (word_cnt_q < rx_pos_q);
  assign tx_crc_en = (word_cnt_q == '0) || (word_cnt_q < tx_pos_q);

  logic rx_err_c, tx_err_c, trunc_c, any_err_c;
  assign rx_err_c  = known_q && (rx_pos_q != '0) && (rx_pos_q < word_cnt_q) &&
                     (rx_cap_q != (rx_crc_q ^ CRC_FINAL));
  assign tx_err_c  = known_q && (tx_pos_q != '0) && (tx_pos_q < word_cnt_q) &&
                     (tx_cap_q != (tx_crc_q ^ CRC_FINAL));
  assign trunc_c   = (bit_cnt_q != '0);
  assign any_err_c = rx_err_c | tx_err_c | trunc_c | ~known_q;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q    <= StIdle;
      flush_q    <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      rx_sr_q    <= '0;
      tx_sr_q    <= '0;
      rx_crc_q   <= '0;
      tx_crc_q   <= '0;
      rx_cap_q   <= '0;
      tx_cap_q   <= '0;
      code_q     <= '0;
      rx_pos_q   <= '0;
      tx_pos_q   <= '0;
      known_q    <= 1'b0;
      frame_done <= 1'b0;
      cmd_known  <= 1'b0;
      cmd_code   <= '0;
      word_cnt   <= '0;
      rx_crc_err <= 1'b0;
      tx_crc_err <= 1'b0;
      trunc_err  <= 1'b0;
      err_cnt    <= '0;
    end else begin
      frame_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // The reset value of the csb synchroniser is not an observation of
          // the bus; wait until it has been refilled before trusting it.
          if (flush_q != 2'd2) begin
            flush_q <= flush_q + 2'd1;
          end else if (csb_sync[1]) begin
            state_q <= StArmed;
          end
        end
        StArmed: begin
          if (csb_fall) begin
            state_q    <= StActive;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            rx_sr_q    <= '0;
            tx_sr_q    <= '0;
            rx_crc_q   <= CRC_INIT;
            tx_crc_q   <= CRC_INIT;
            rx_cap_q   <= '0;
            tx_cap_q   <= '0;
            code_q     <= '0;
            rx_pos_q   <= '0;
            tx_pos_q   <= '0;
            known_q    <= 1'b0;
          end
        end
        StActive: begin
          // A sample edge coinciding with csb rising is still shifted in.
          if (sample_edge) begin
            rx_sr_q <= rx_word[DATA_WIDTH-2:0];
            tx_sr_q <= tx_word[DATA_WIDTH-2:0];
            if (rx_crc_en) rx_crc_q <= crc_step(rx_crc_q, mosi_bit);
            if (tx_crc_en) tx_crc_q <= crc_step(tx_crc_q, miso_bit);
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_q <= '0;
              if (word_cnt_q != WORD_MAX) word_cnt_q <= word_cnt_q + 1'b1;
              if (word_cnt_q == '0) begin
                code_q   <= rx_word;
                known_q  <= hit;
                rx_pos_q <= hit_rx;
                tx_pos_q <= hit_tx;
              end else begin
                if (word_cnt_q == rx_pos_q) rx_cap_q <= rx_word;
                if (word_cnt_q == tx_pos_q) tx_cap_q <= tx_word;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
          if (csb_rise) state_q <= StCheck;
        end
        StCheck: begin
          state_q    <= StArmed;
          frame_done <= 1'b1;
          cmd_known  <= known_q;
          cmd_code   <= code_q;
          word_cnt   <= word_cnt_q;
          rx_crc_err <= rx_err_c;
          tx_crc_err <= tx_err_c;
          trunc_err  <= trunc_c;
          if (any_err_c && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
